// File: rtl/sisc_exec_ctrl.sv
// SISC execution core: 32-bit ALU, branch target/condition logic and multicycle control FSM with CC register.
// Latency: ALU and br_addr combinational; stat registered at end of EXECUTE; 5 cycles per instruction. No backpressure.
// Optional: define ALU_MULT_EN to enable funct 8 = MUL (low 32 bits of A*B).
module sisc_exec_ctrl (
    input  logic        clk,
    input  logic        rst_f,
    input  logic [31:0] ir,
    input  logic [31:0] rsa,
    input  logic [31:0] rsb,
    input  logic [15:0] pc_inc,
    output logic [31:0] alu_result,
    output logic [3:0]  stat,
    output logic [15:0] br_addr,
    output logic        rf_we,
    output logic        wb_sel,
    output logic        rb_sel,
    output logic        pc_rst,
    output logic        pc_sel,
    output logic        pc_write,
    output logic        ir_load
);

    typedef enum logic [2:0] {
        START0, START1, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT
    } state_t;

    state_t state, next_state;

    logic [3:0]  opcode;
    logic [3:0]  funct;
    logic [15:0] imm;
    logic [31:0] op_a, op_b;
    logic [32:0] sum33, shl33, shr33;
    logic [31:0] diff;
    logic        c_flag, v_flag;
    logic        is_alu_op;
    logic        is_branch, mm_hit, br_taken;
    logic        unused_ir;

    assign opcode    = ir[31:28];
    assign funct     = ir[27:24];
    assign imm       = ir[15:0];
    assign unused_ir = ^ir[23:16];
    assign is_alu_op = (opcode == 4'h1) || (opcode == 4'h2);

    assign op_a  = rsa;
    assign op_b  = (opcode == 4'h2) ? {{16{imm[15]}}, imm} : rsb;
    assign sum33 = {1'b0, op_a} + {1'b0, op_b};
    assign diff  = op_a - op_b;
    // Extra bit catches the last bit shifted out; it stays 0 for a zero shift.
    assign shl33 = {1'b0, op_a} << op_b[4:0];
    assign shr33 = {op_a, 1'b0} >> op_b[4:0];

`ifdef ALU_MULT_EN
    logic [63:0] prod;
    assign prod = op_a * op_b;
`endif

    always_comb begin
        alu_result = 32'd0;
        c_flag     = 1'b0;
        v_flag     = 1'b0;
        case (funct)
            4'h0: begin
                alu_result = sum33[31:0];
                c_flag     = sum33[32];
                v_flag     = (op_a[31] == op_b[31]) && (sum33[31] != op_a[31]);
            end
            4'h1: begin
                alu_result = diff;
                c_flag     = op_a < op_b;
                v_flag     = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
            end
            4'h2: alu_result = ~op_a;
            4'h3: alu_result = op_a | op_b;
            4'h4: alu_result = op_a & op_b;
            4'h5: alu_result = op_a ^ op_b;
            4'h6: begin
                alu_result = shl33[31:0];
                c_flag     = shl33[32];
            end
            4'h7: begin
                alu_result = shr33[32:1];
                c_flag     = shr33[0];
            end
`ifdef ALU_MULT_EN
            4'h8: begin
                alu_result = prod[31:0];
                c_flag     = |prod[63:32];
            end
`endif
            default: alu_result = 32'd0;
        endcase
    end

    // Opcodes 4..7: bit0 selects relative target, bit1 inverts the condition.
    assign is_branch = (opcode[3:2] == 2'b01);
    assign mm_hit    = |(funct & stat);
    assign br_taken  = is_branch &&
                       (opcode[1] ? !mm_hit : ((funct == 4'h0) || mm_hit));
    assign br_addr   = (is_branch && opcode[0]) ? (pc_inc + imm) : imm;

    always_ff @(posedge clk) begin
        if (rst_f) begin
            state <= START0;
            stat  <= 4'd0;
        end else begin
            state <= next_state;
            if (state == EXECUTE && is_alu_op)
                stat <= {c_flag, v_flag, alu_result[31], (alu_result == 32'd0)};
        end
    end

    always_comb begin
        next_state = state;
        rf_we      = 1'b0;
        wb_sel     = 1'b0;
        rb_sel     = 1'b0;
        pc_rst     = 1'b0;
        pc_sel     = 1'b0;
        pc_write   = 1'b0;
        ir_load    = 1'b0;
        case (state)
            START0: begin
                pc_rst     = 1'b1;
                next_state = START1;
            end
            START1:  next_state = FETCH;
            FETCH: begin
                ir_load    = 1'b1;
                pc_write   = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                pc_sel     = br_taken;
                pc_write   = br_taken;
                next_state = (opcode == 4'hF) ? HALT : EXECUTE;
            end
            EXECUTE: next_state = MEM;
            MEM:     next_state = WRITEBACK;
            WRITEBACK: begin
                rf_we      = is_alu_op;
                next_state = FETCH;
            end
            default: next_state = HALT;
        endcase
    end

endmodule

// File: tb/tb_sisc_exec_ctrl.sv
// Bench for sisc_exec_ctrl: instruction table drives the core, expected results go through a scoreboard queue.
module tb_sisc_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_f;
    logic [31:0] ir, rsa, rsb;
    logic [15:0] pc_inc;
    logic [31:0] alu_result;
    logic [3:0]  stat;
    logic [15:0] br_addr;
    logic        rf_we, wb_sel, rb_sel, pc_rst, pc_sel, pc_write, ir_load;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] rsa;
        logic [31:0] rsb;
        logic [15:0] pc;
        logic [31:0] alu;
        logic [3:0]  st;
        logic [15:0] br;
        logic        tk;
        logic        we;
    } vec_t;

    vec_t prog[$];
    vec_t exp_q[$];

    sisc_exec_ctrl dut (
        .clk(clk), .rst_f(rst_f), .ir(ir), .rsa(rsa), .rsb(rsb), .pc_inc(pc_inc),
        .alu_result(alu_result), .stat(stat), .br_addr(br_addr),
        .rf_we(rf_we), .wb_sel(wb_sel), .rb_sel(rb_sel), .pc_rst(pc_rst),
        .pc_sel(pc_sel), .pc_write(pc_write), .ir_load(ir_load)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [31:0] i_ir, input logic [31:0] a, input logic [31:0] b,
                           input logic [15:0] pc, input logic [31:0] res, input logic [3:0] st,
                           input logic [15:0] br, input logic tk, input logic we);
        vec_t v;
        v.ir = i_ir; v.rsa = a; v.rsb = b; v.pc = pc; v.alu = res;
        v.st = st; v.br = br; v.tk = tk; v.we = we;
        prog.push_back(v);
    endtask

    task automatic test_reset;
        rst_f = 1'b1; ir = 32'd0; rsa = 32'd0; rsb = 32'd0; pc_inc = 16'd0;
        repeat (2) tick();
        rst_f = 1'b0;
        total++;
        if ({pc_rst, ir_load, pc_write, stat} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
            bad++;
            $display("FAIL reset_start0: got pc_rst/ir_load/pc_write/stat=%b required 1000000",
                     {pc_rst, ir_load, pc_write, stat});
        end
        tick();
        total++;
        if ({pc_rst, ir_load, pc_write} !== 3'b000) begin
            bad++;
            $display("FAIL reset_start1: got pc_rst/ir_load/pc_write=%b required 000",
                     {pc_rst, ir_load, pc_write});
        end
        tick();
        total++;
        if ({pc_rst, ir_load, pc_write, pc_sel} !== 4'b0110) begin
            bad++;
            $display("FAIL reset_fetch: got pc_rst/ir_load/pc_write/pc_sel=%b required 0110",
                     {pc_rst, ir_load, pc_write, pc_sel});
        end
    endtask

    task automatic test_program;
        vec_t v, e;
        for (int i = 0; i < prog.size(); i++) begin
            v = prog[i];
            ir = v.ir; rsa = v.rsa; rsb = v.rsb; pc_inc = v.pc;
            exp_q.push_back(v);
            total++;
            if ({ir_load, pc_write, pc_sel, rf_we, wb_sel, rb_sel} !== 6'b110000) begin
                bad++;
                $display("FAIL fetch[%0d]: got ctl=%b required 110000", i,
                         {ir_load, pc_write, pc_sel, rf_we, wb_sel, rb_sel});
            end
            tick();
            e = exp_q.pop_front();
            total++;
            if ({pc_write, pc_sel, br_addr} !== {e.tk, e.tk, e.br}) begin
                bad++;
                $display("FAIL decode[%0d]: got pc_write=%b pc_sel=%b br_addr=%h required %b %b %h",
                         i, pc_write, pc_sel, br_addr, e.tk, e.tk, e.br);
            end
            tick();
            total++;
            if (alu_result !== e.alu || rf_we !== 1'b0) begin
                bad++;
                $display("FAIL execute[%0d]: got alu_result=%h rf_we=%b required %h 0",
                         i, alu_result, rf_we, e.alu);
            end
            tick();
            total++;
            if (stat !== e.st) begin
                bad++;
                $display("FAIL stat[%0d]: got %b required %b", i, stat, e.st);
            end
            tick();
            total++;
            if ({rf_we, pc_write, ir_load} !== {e.we, 2'b00}) begin
                bad++;
                $display("FAIL writeback[%0d]: got rf_we/pc_write/ir_load=%b required %b00",
                         i, {rf_we, pc_write, ir_load}, e.we);
            end
            tick();
        end
    endtask

    task automatic test_midreset;
        ir = 32'h10000000; rsa = 32'd1; rsb = 32'd1;
        tick();
        tick();
        rst_f = 1'b1;
        tick();
        rst_f = 1'b0;
        total++;
        if ({pc_rst, stat} !== 5'b10000) begin
            bad++;
            $display("FAIL midreset: got pc_rst/stat=%b required 10000", {pc_rst, stat});
        end
        tick();
        tick();
        total++;
        if ({ir_load, pc_write} !== 2'b11) begin
            bad++;
            $display("FAIL midreset_fetch: got ir_load/pc_write=%b required 11", {ir_load, pc_write});
        end
    endtask

    task automatic test_halt;
        ir = 32'hF0000000; rsa = 32'd0; rsb = 32'd0; pc_inc = 16'd0;
        tick();
        total++;
        if ({pc_write, pc_sel} !== 2'b00) begin
            bad++;
            $display("FAIL halt_decode: got pc_write/pc_sel=%b required 00", {pc_write, pc_sel});
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if ({rf_we, wb_sel, rb_sel, pc_rst, pc_sel, pc_write, ir_load} !== 7'd0) begin
                bad++;
                $display("FAIL halt[%0d]: got outputs=%b required 0000000", k,
                         {rf_we, wb_sel, rb_sel, pc_rst, pc_sel, pc_write, ir_load});
            end
        end
        rst_f = 1'b1;
        tick();
        rst_f = 1'b0;
        total++;
        if (pc_rst !== 1'b1) begin
            bad++;
            $display("FAIL halt_exit: got pc_rst=%b required 1", pc_rst);
        end
    endtask

    initial begin
        add_vec(32'h5100FFFC, 32'd0, 32'd0, 16'h0010, 32'h0, 4'b0000, 16'h000C, 1'b0, 1'b0);
        add_vec(32'h21120005, 32'd5, 32'd0, 16'h0000, 32'h0, 4'b0001, 16'h0005, 1'b0, 1'b1);
        add_vec(32'h5100FFFC, 32'd0, 32'd0, 16'h0010, 32'h0, 4'b0001, 16'h000C, 1'b1, 1'b0);
        add_vec(32'h10123000, 32'h7FFFFFFF, 32'd1, 16'h0000, 32'h80000000, 4'b0110, 16'h3000, 1'b0, 1'b1);
        add_vec(32'h61000040, 32'd0, 32'd0, 16'h0000, 32'h0, 4'b0110, 16'h0040, 1'b1, 1'b0);
        add_vec(32'h16000000, 32'h80000001, 32'd1, 16'h0000, 32'h2, 4'b1000, 16'h0000, 1'b0, 1'b1);
        add_vec(32'h42000100, 32'd0, 32'd0, 16'h0000, 32'hFFFFFFFF, 4'b1000, 16'h0100, 1'b0, 1'b0);
        add_vec(32'h11000000, 32'd1, 32'd2, 16'h0000, 32'hFFFFFFFF, 4'b1010, 16'h0000, 1'b0, 1'b1);
        add_vec(32'h1A000000, 32'd5, 32'd6, 16'h0000, 32'h0, 4'b0001, 16'h0000, 1'b0, 1'b1);
        add_vec(32'h71000008, 32'd0, 32'd0, 16'h0020, 32'h0, 4'b0001, 16'h0028, 1'b0, 1'b0);
        add_vec(32'h17000000, 32'd3, 32'd1, 16'h0000, 32'h1, 4'b1000, 16'h0000, 1'b0, 1'b1);
        add_vec(32'h2500FFFF, 32'h0000FFFF, 32'd0, 16'h0000, 32'hFFFF0000, 4'b0010, 16'hFFFF, 1'b0, 1'b1);
        add_vec(32'h30000000, 32'd0, 32'd0, 16'h0000, 32'h0, 4'b0010, 16'h0000, 1'b0, 1'b0);
`ifdef ALU_MULT_EN
        add_vec(32'h18000000, 32'd3, 32'd4, 16'h0000, 32'd12, 4'b0000, 16'h0000, 1'b0, 1'b1);
`else
        add_vec(32'h18000000, 32'd3, 32'd4, 16'h0000, 32'd0, 4'b0001, 16'h0000, 1'b0, 1'b1);
`endif
        add_vec(32'h40001234, 32'd0, 32'd0, 16'h0000, 32'h0, 4'b0001, 16'h1234, 1'b1, 1'b0);

        test_reset();
        test_program();
        test_midreset();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
